// File: rtl/way_pkg.sv
// -----------------------------------------------------------------------------
// way_pkg
// Shared types and helpers for one way of a set-associative cache.
//   op_e     : request opcode, encoded as {cmp, write}
//   state_e  : controller states of way_set
//   idx_width: address width for a power-of-two count (at least 1 bit)
// -----------------------------------------------------------------------------
package way_pkg;

  typedef enum logic [1:0] {
    OP_READ      = 2'b00,
    OP_FILL      = 2'b01,
    OP_CMP_READ  = 2'b10,
    OP_CMP_WRITE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DONE  = 2'd1,
    S_FLUSH = 2'd2,
    S_FDONE = 2'd3
  } state_e;

  // A single-entry array still needs a 1-bit select so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/way_set_if.sv
// -----------------------------------------------------------------------------
// way_set_if
// Request/response bundle between the cache controller and one cache way.
//   master (controller): drives enable, cmp, write, index, word, tag, data_in,
//                        valid_in, flush; observes the response signals.
//   slave  (way_set)   : drives hit, dirty, tag_out, data_out, valid, ack,
//                        busy, flush_done.
// enable is held until ack, flush is held until flush_done (four-phase).
// -----------------------------------------------------------------------------
interface way_set_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int WORDS  = 4,
  parameter int SETS   = 8
);
  import way_pkg::*;

  localparam int WORD_W = idx_width(WORDS);
  localparam int IDX_W  = idx_width(SETS);

  logic              enable;
  logic              cmp;
  logic              write;
  logic [IDX_W-1:0]  index;
  logic [WORD_W-1:0] word;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              flush;

  logic              hit;
  logic              dirty;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ack;
  logic              busy;
  logic              flush_done;

  modport master (
    output enable, cmp, write, index, word, tag, data_in, valid_in, flush,
    input  hit, dirty, tag_out, data_out, valid, ack, busy, flush_done
  );

  modport slave (
    input  enable, cmp, write, index, word, tag, data_in, valid_in, flush,
    output hit, dirty, tag_out, data_out, valid, ack, busy, flush_done
  );

endinterface

// File: rtl/way_line_mem.sv
// -----------------------------------------------------------------------------
// way_line_mem
// Data (SETS x WORDS x DATA_W) and tag (SETS x TAG_W) storage for one way.
// One shared write address; data and tag have separate write enables.
// Reads are asynchronous, so the value seen in the write cycle is the
// pre-write contents.
//   clk     : write clock
//   we      : write w_data to data[index][word]
//   tag_we  : write w_tag to tag[index]
//   index   : line select (read and write)
//   word    : word select (read and write)
//   rd_data : data[index][word]
//   rd_tag  : tag[index]
// -----------------------------------------------------------------------------
module way_line_mem
  import way_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int WORDS  = 4,
  parameter int SETS   = 8,
  localparam int WORD_W = idx_width(WORDS),
  localparam int IDX_W  = idx_width(SETS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              tag_we,
  input  logic [IDX_W-1:0]  index,
  input  logic [WORD_W-1:0] word,
  input  logic [DATA_W-1:0] w_data,
  input  logic [TAG_W-1:0]  w_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag
);

  logic [DATA_W-1:0] data_mem [SETS][WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];

  // NOTE: storage arrays carry no reset (line validity lives in resettable
  // flops elsewhere), and clocked state is always written with <= so every
  // flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we)     data_mem[index][word] <= w_data;
    if (tag_we) tag_mem[index]        <= w_tag;
  end

  assign rd_data = data_mem[index][word];
  assign rd_tag  = tag_mem[index];

endmodule

// File: rtl/way_set.sv
// -----------------------------------------------------------------------------
// way_set
// One way of a set-associative cache: SETS lines of WORDS words, with per-line
// tag, valid and dirty. Serves READ / FILL / CMP_READ / CMP_WRITE requests with
// one-cycle latency and runs a SETS-cycle flush sweep clearing valid/dirty.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : way_set_if.slave request/response bundle
// Response values are captured at the accepting edge and held until the next
// request completes; ack, busy and flush_done decode the controller state.
// -----------------------------------------------------------------------------
module way_set
  import way_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int WORDS  = 4,
  parameter int SETS   = 8,
  localparam int IDX_W = idx_width(SETS)
) (
  input logic      clk,
  input logic      rst_n,
  way_set_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(SETS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [SETS-1:0]   valid_q, dirty_q;

  logic              hit_q, dirty_out_q, valid_out_q;
  logic [TAG_W-1:0]  tag_out_q;
  logic [DATA_W-1:0] data_out_q;

  op_e               op;
  logic              accept, tag_match, mem_we, tag_we;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;

  assign op        = op_e'({bus.cmp, bus.write});
  assign tag_match = valid_q[bus.index] && (rd_tag == bus.tag);
  // A compare-write that misses must leave the line untouched.
  assign mem_we    = accept && ((op == OP_FILL) || (op == OP_CMP_WRITE && tag_match));
  assign tag_we    = accept && (op == OP_FILL);

  way_line_mem #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .WORDS  (WORDS),
    .SETS   (SETS)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .tag_we  (tag_we),
    .index   (bus.index),
    .word    (bus.word),
    .w_data  (bus.data_in),
    .w_tag   (bus.tag),
    .rd_data (rd_data),
    .rd_tag  (rd_tag)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // flush has priority; a held request waits for the sweep to finish
        if (bus.flush) begin
          state_d = S_FLUSH;
        end else if (bus.enable) begin
          accept  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  if (!bus.enable)       state_d = S_IDLE;
      S_FLUSH: if (cnt_q == LAST_LINE) state_d = S_FDONE;
      S_FDONE: if (!bus.flush)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sweep pointer: restarts at 0 whenever idle and parks on the last line so
  // it only returns to 0 through the exit back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (state_q == S_FLUSH && cnt_q != LAST_LINE) begin
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == S_FLUSH) begin
      valid_q[cnt_q] <= 1'b0;
      dirty_q[cnt_q] <= 1'b0;
    end else if (accept) begin
      if (op == OP_FILL) begin
        valid_q[bus.index] <= bus.valid_in;
        dirty_q[bus.index] <= 1'b0;
      end else if (op == OP_CMP_WRITE && tag_match) begin
        dirty_q[bus.index] <= 1'b1;
      end
    end
  end

  // Responses reflect the line as it was before this request's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= 1'b0;
      dirty_out_q <= 1'b0;
      valid_out_q <= 1'b0;
      tag_out_q   <= '0;
      data_out_q  <= '0;
    end else if (accept) begin
      hit_q       <= bus.cmp && tag_match;
      dirty_out_q <= dirty_q[bus.index];
      valid_out_q <= valid_q[bus.index];
      tag_out_q   <= rd_tag;
      data_out_q  <= rd_data;
    end
  end

  assign bus.hit        = hit_q;
  assign bus.dirty      = dirty_out_q;
  assign bus.valid      = valid_out_q;
  assign bus.tag_out    = tag_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.ack        = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.flush_done = (state_q == S_FDONE);

endmodule
